// File: rtl/sipo_cfg_loader_if.sv
// Host-side valid/ready handshake carrying the 27-bit configuration word
// into sipo_cfg_loader.
interface sipo_cfg_loader_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [26:0] cfg_data;

  modport master (output cfg_valid, output cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_data, output cfg_ready);
endinterface

// File: rtl/sipo_cfg_loader.sv
// Loads a 27-bit config word into the SIPO chain: clear, marker + LSB-first shift, wait for finished.
// Optional WAIT_FIN timeout is enabled with `define SIPO_CFG_TIMEOUT_EN.
module sipo_cfg_loader #(
  parameter int CLR_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic             clock,
  input  logic             rst,
  sipo_cfg_loader_if.slave cfg,
  output logic             sipo_rst_n,
  output logic             ser_data,
  output logic             ser_en,
  input  logic             sipo_finished,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  localparam logic [3:0] CLR_LAST = 4'(CLR_CYCLES - 1);
  localparam logic [4:0] LAST_BIT = 5'd27;

  logic [2:0]  state;
  logic [26:0] hold;
  logic [3:0]  clr_cnt;
  logic [4:0]  bit_cnt;
  logic        accept;
  logic        to_expired;

  assign cfg.cfg_ready = (state == S_IDLE) || (state == S_ERR);
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;
  assign busy          = (state == S_CLEAR) || (state == S_SHIFT) || (state == S_WAIT);
  assign done          = (state == S_DONE);
  assign error         = (state == S_ERR);

`ifdef SIPO_CFG_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] to_cnt;

  // Restarts from zero on every entry into WAIT_FIN
  always_ff @(posedge clock or negedge rst) begin
    if (!rst)
      to_cnt <= '0;
    else if (state != S_WAIT)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 8'd1;
  end

  assign to_expired = (to_cnt == TO_LAST);
`else
  // Without the timeout WAIT_FIN never expires
  assign to_expired = (TIMEOUT_CYCLES < 0);
`endif

  // Chain-side outputs are computed from the next state so they come straight from flops
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      hold       <= '0;
      clr_cnt    <= '0;
      bit_cnt    <= '0;
      sipo_rst_n <= 1'b0;
      ser_en     <= 1'b0;
      ser_data   <= 1'b0;
    end else begin
      sipo_rst_n <= 1'b1;
      ser_en     <= 1'b0;
      ser_data   <= 1'b0;
      case (state)
        S_IDLE, S_ERR: begin
          if (accept) begin
            hold       <= cfg.cfg_data;
            clr_cnt    <= '0;
            sipo_rst_n <= 1'b0;
            state      <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (clr_cnt == CLR_LAST) begin
            bit_cnt  <= '0;
            ser_en   <= 1'b1;
            ser_data <= 1'b1;
            state    <= S_SHIFT;
          end else begin
            clr_cnt    <= clr_cnt + 4'd1;
            sipo_rst_n <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (sipo_finished && (bit_cnt != LAST_BIT)) begin
            state <= S_ERR;
          end else if (bit_cnt == LAST_BIT) begin
            state <= S_WAIT;
          end else begin
            // Next bit position k+1 carries hold[k]
            bit_cnt  <= bit_cnt + 5'd1;
            ser_en   <= 1'b1;
            ser_data <= hold[bit_cnt];
          end
        end
        S_WAIT: begin
          if (sipo_finished)
            state <= S_DONE;
          else if (to_expired)
            state <= S_ERR;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_cfg_loader.sv
// Self-checking bench for sipo_cfg_loader: model shift chain plus a cycle-offset
// reference model of the load sequence, table vectors, random loads and corner cases.
module tb_sipo_cfg_loader;

  localparam int CLR = 2;
  localparam int TO  = 15;

  logic clock = 1'b0;
  logic rst   = 1'b0;
  logic sipo_rst_n, ser_data, ser_en, sipo_finished, busy, done, error;

  sipo_cfg_loader_if cfg_bus ();

  sipo_cfg_loader #(.CLR_CYCLES(CLR), .TIMEOUT_CYCLES(TO)) dut (
    .clock         (clock),
    .rst           (rst),
    .cfg           (cfg_bus),
    .sipo_rst_n    (sipo_rst_n),
    .ser_data      (ser_data),
    .ser_en        (ser_en),
    .sipo_finished (sipo_finished),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  always #5 clock = ~clock;

  // Model chain: marker enters at the top and reaches bit 0 after 28 shifts
  logic [27:0] chain;
  logic        force_on  = 1'b0;
  logic        force_val = 1'b0;

  always @(posedge clock or negedge sipo_rst_n) begin
    if (!sipo_rst_n)
      chain <= '0;
    else if (ser_en)
      chain <= {ser_data, chain[27:1]};
  end

  assign sipo_finished = force_on ? force_val : chain[0];

  typedef struct {
    logic [26:0] data;
    int          fin_k;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [26:0] data);
    cfg_bus.cfg_valid = valid;
    cfg_bus.cfg_data  = data;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [6:0] outs();
    return {cfg_bus.cfg_ready, busy, done, error, sipo_rst_n, ser_en, ser_data};
  endfunction

  // Expected outputs n cycles after the accept edge of word w
  function automatic logic [6:0] load_model(input int n, input logic [26:0] w);
    logic rstn, en, sd;
    int   k;
    k    = n - CLR;
    rstn = (n >= CLR);
    en   = (k >= 0) && (k <= 27);
    sd   = en ? ((k == 0) ? 1'b1 : w[k-1]) : 1'b0;
    return {(n >= CLR + 30), (n <= CLR + 28), (n == CLR + 29), 1'b0, rstn, en, sd};
  endfunction

  // Full load; fin_k >= 0 forces a premature finish while bit k is on the line
  task automatic run_load(input logic [26:0] w, input int fin_k);
    int last;
    last = (fin_k >= 0) ? CLR + fin_k + 1 : CLR + 30;
    applyStimulus(1'b1, w);
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_data  = 27'($urandom);
    for (int n = 0; n <= last; n++) begin
      if (n > 0) begin
        @(posedge clock);
        #1;
      end
      if (fin_k >= 0 && n == last) begin
        checkOutput("err state", 32'(outs()), 32'(7'b1001100));
        force_on = 1'b0;
      end else begin
        checkOutput($sformatf("load n=%0d", n), 32'(outs()), 32'(load_model(n, w)));
        if (n == CLR + 29)
          checkOutput("chain word", 32'(chain[27:1]), 32'(w));
      end
      if (fin_k >= 0 && n == CLR + fin_k) begin
        force_on  = 1'b1;
        force_val = 1'b1;
      end
    end
  endtask

  initial begin
    vec_t        vecs[8];
    logic [26:0] q[$];
    logic [26:0] w;
    int          n_since;
    int          model_loads;
    int          dut_dones;
    bit          acc;

    vecs[0] = '{27'h5A5_A5A,  -1};
    vecs[1] = '{27'h000_0000, -1};
    vecs[2] = '{27'h7FF_FFFF, -1};
    vecs[3] = '{27'h123_4567, 10};
    vecs[4] = '{27'h0AB_CDEF, -1};
    vecs[5] = '{27'h2AA_AAAA,  0};
    vecs[6] = '{27'h555_5555, 26};
    vecs[7] = '{27'h400_0001, -1};

    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_data  = '0;
    #1;
    checkOutput("reset values", 32'(outs()), 32'(7'b1000000));
    @(posedge clock);
    #1;
    checkOutput("reset held", 32'(outs()), 32'(7'b1000000));
    rst = 1'b1;
    checkOutput("rst_n before edge", 32'(sipo_rst_n), 32'd0);
    applyStimulus(1'b0, 27'h1FF_FFFF);
    checkOutput("after release", 32'(outs()), 32'(7'b1000100));

    for (int i = 0; i < 8; i++)
      run_load(vecs[i].data, vecs[i].fin_k);

    // Random loads with idle gaps carrying junk data
    for (int i = 0; i < 8; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        checkOutput("gap ready", 32'({cfg_bus.cfg_ready, busy}), 32'(2'b10));
        applyStimulus(1'b0, 27'($urandom));
      end
      run_load(27'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 26)) : -1);
    end

    // Reset in the middle of the shift at k = 14
    applyStimulus(1'b1, 27'h2DB_6DB6);
    cfg_bus.cfg_valid = 1'b0;
    for (int n = 1; n <= CLR + 14; n++) begin
      @(posedge clock);
      #1;
    end
    checkOutput("mid shift en", 32'(ser_en), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("mid reset", 32'(outs()), 32'(7'b1000000));
    for (int n = 0; n < 3; n++) begin
      applyStimulus(1'b0, '0);
      checkOutput("in reset", 32'(outs()), 32'(7'b1000000));
    end
    rst = 1'b1;
    applyStimulus(1'b0, '0);
    checkOutput("reset recover", 32'(outs()), 32'(7'b1000100));
    run_load(27'h3C3_C3C3, -1);

    // cfg_valid held high with changing data: only IDLE acceptances count
    n_since     = 1000;
    model_loads = 0;
    dut_dones   = 0;
    for (int i = 0; i < 150; i++) begin
      w   = 27'($urandom);
      acc = (i < 110) && (n_since >= CLR + 30);
      checkOutput("held ready", 32'(cfg_bus.cfg_ready), 32'(n_since >= CLR + 30));
      if (acc) begin
        q.push_back(w);
        model_loads++;
      end
      applyStimulus(i < 110, w);
      n_since = acc ? 0 : n_since + 1;
      if (done)
        dut_dones++;
      if (n_since == CLR + 29) begin
        checkOutput("held done", 32'(done), 32'd1);
        if (q.size() > 0)
          checkOutput("held word", 32'(chain[27:1]), 32'(q.pop_front()));
      end
    end
    checkOutput("held load count", 32'(dut_dones), 32'(model_loads));

    // Chain never finishes
    force_on  = 1'b1;
    force_val = 1'b0;
    applyStimulus(1'b1, 27'h155_5555);
    cfg_bus.cfg_valid = 1'b0;
`ifdef SIPO_CFG_TIMEOUT_EN
    for (int n = 1; n <= CLR + 28 + TO; n++) begin
      @(posedge clock);
      #1;
      if (n == CLR + 28 + TO - 1)
        checkOutput("before timeout", 32'({busy, error}), 32'(2'b10));
    end
    checkOutput("timeout err", 32'(outs()), 32'(7'b1001100));
`else
    for (int n = 1; n <= 120; n++) begin
      @(posedge clock);
      #1;
      checkOutput("wait forever busy", 32'({busy, done, error}), 32'(3'b100));
    end
`endif
    force_on = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("final reset", 32'(outs()), 32'(7'b1000000));
    rst = 1'b1;
    applyStimulus(1'b0, '0);
    run_load(27'h6E6_1F0D, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_cfg_loader.md
# sipo_cfg_loader

Sequencer that takes a 27-bit configuration word over a valid/ready handshake and loads it into the serial-in/parallel-out configuration shift chain. It drives the chain's clear, serial data and shift enable, waits for the chain's `finished` flag, and reports done or error. It sits between the host-side register/command logic and the configuration shift chain, and is the only agent that drives the chain's inputs.

## Interface
Parameters:
- `CLR_CYCLES`, default 2: cycles the chain clear is held active before shifting (1–15).
- `TIMEOUT_CYCLES`, default 15: cycles allowed in WAIT_FIN for `sipo_finished` (1–255; used only with `SIPO_CFG_TIMEOUT_EN`).

Ports:
- `clock`: input, 1 bit, single clock for the block.
- `rst`: input, 1 bit, asynchronous active-low reset.
- `cfg_valid`: input, 1 bit, host offers `cfg_data`.
- `cfg_ready`: output, 1 bit, block can accept a word.
- `cfg_data`: input, 27 bits; `[26]` = out_sel, `[25]` = clk_sel, `[24:0]` = five 5-bit fields.
- `sipo_rst_n`: output, 1 bit, active-low clear to the chain.
- `ser_data`: output, 1 bit, serial bit to the chain.
- `ser_en`: output, 1 bit, chain shift enable.
- `sipo_finished`: input, 1 bit, chain's marker-arrived flag.
- `busy`: output, 1 bit, high in CLEAR, SHIFT and WAIT_FIN.
- `done`: output, 1 bit, one-cycle pulse on successful load.
- `error`: output, 1 bit, level, set on failure and cleared on the next accept.

## Operation
- States: IDLE, CLEAR, SHIFT, WAIT_FIN, DONE, ERR.
- Accept: when `cfg_valid & cfg_ready` at a rising edge, `cfg_data` is captured into a 27-bit holding register.
  - The FSM moves to CLEAR and `error` is cleared.
  - `cfg_ready` = 1 only in IDLE and ERR.
  - `cfg_data` is ignored at all other times.
- CLEAR: `sipo_rst_n` = 0 for exactly `CLR_CYCLES` cycles; `ser_en` = 0. The FSM then moves to SHIFT.
- SHIFT: exactly 28 cycles with `ser_en` = 1, driven by a 5-bit bit counter k = 0..27.
  - k = 0: `ser_data` = 1 (start marker).
  - k = 1..27: `ser_data` = holding[k-1], i.e. LSB first, with out_sel last.
  - After k = 27 the FSM moves to WAIT_FIN.
- Premature finish: `sipo_finished` sampled 1 in SHIFT while k < 27 → ERR.
- WAIT_FIN: `ser_en` = 0 and `ser_data` = 0.
  - `sipo_finished` = 1 → DONE.
  - Timeout handling is described under Configuration.
- DONE: lasts one cycle with `done` = 1, then the FSM moves to IDLE.
- ERR: `error` = 1 and `cfg_ready` = 1. The FSM stays in ERR until the next accept, which restarts from CLEAR.
- `ser_en`, `ser_data` and `sipo_rst_n` are registered outputs, free of combinational paths from inputs.

## Timing
- Reset values (async, `rst` = 0):
  - FSM = IDLE.
  - `cfg_ready` = 1 and `sipo_rst_n` = 0.
  - `ser_en` = 0, `ser_data` = 0, `busy` = 0, `done` = 0, `error` = 0.
  - Holding register and counters = 0.
- `sipo_rst_n` rises to 1 on the first clock edge after reset release.
- Accept at edge E0. CLEAR covers the cycles after E0 through E`CLR_CYCLES`.
- SHIFT: `ser_en` is high for the 28 cycles after E`CLR_CYCLES`.
- With the chain asserting `finished` right after the 28th enabled edge, `done` is high in the cycle after edge E(`CLR_CYCLES`+29). Default accept-to-done = 31 cycles.
- Back-to-back loads: `cfg_ready` returns in IDLE one cycle after `done`.
- Reset mid-operation: an immediate return to reset values.
  - `sipo_rst_n` = 0 clears any partial load.
  - No `done` or `error` is produced.
- `cfg_valid` held high across DONE→IDLE is accepted in IDLE only, never in DONE.

## Configuration
- `SIPO_CFG_TIMEOUT_EN` defined:
  - An 8-bit counter runs in WAIT_FIN.
  - If `sipo_finished` is still 0 after `TIMEOUT_CYCLES` cycles, the FSM moves to ERR.
  - `sipo_finished` = 1 on the same cycle as expiry wins, giving DONE.
- Not defined:
  - WAIT_FIN waits indefinitely; only reset or `sipo_finished` leaves it.
  - The counter is not synthesized.

## Test plan
- Reset release with `cfg_valid` = 0 → `cfg_ready` = 1, `busy` = 0, `sipo_rst_n` = 0 then 1 after one edge; all other outputs 0.
- Accept `cfg_data` = 27'h5A5_A5A with a model chain → `sipo_rst_n` low for 2 cycles; 28 `ser_en` cycles carrying 1 then data LSB first; `done` pulse at cycle 31; chain parallel outputs equal 27'h5A5_A5A.
- Force `sipo_finished` = 1 at shift k = 10 → `error` = 1 and `cfg_ready` = 1; next accept clears `error` and a reload completes with `done`.
- `SIPO_CFG_TIMEOUT_EN`, chain `finished` stuck 0 → ERR exactly 15 cycles after entering WAIT_FIN. Without the macro → `busy` stays 1 for 100+ cycles.
- Assert `rst` = 0 at shift k = 14 → all outputs at reset values, no `done`; a fresh load afterwards completes with correct data.
- `cfg_valid` held high for 80 cycles with changing data → only words presented while `cfg_ready` = 1 are loaded; consecutive loads are spaced by at least 32 cycles.
